// File: rtl/best_hop_select.sv
// -----------------------------------------------------------------------------
// best_hop_select
//
// Scans the neighbor routing table held in shared data memory and picks the
// best next hop: the eligible neighbor with the highest qValue. Eligibility
// means the neighbor is not the excluded sender and its battery meets the
// minimum. Ties keep the lowest table index. The block only reads memory.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        begin a scan (accepted only when idle or done)
//   min_battery  minimum batteryStat for eligibility (unsigned)
//   exclude_id   neighbor ID that is never selected
//   data_in      memory read data for the current address
//   address      registered memory byte address (word stride 2)
//   busy         scan in progress
//   done         scan finished; results valid and held until next start
//   found        an eligible neighbor was found
//   best_id      selected neighbor ID
//   best_q       selected neighbor qValue
//   best_cluster selected neighbor clusterID
//   best_index   table index of the selected neighbor
// -----------------------------------------------------------------------------
module best_hop_select #(
    parameter int MAX_NEIGHBORS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] min_battery,
    input  logic [15:0] exclude_id,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [15:0] best_id,
    output logic [15:0] best_q,
    output logic [15:0] best_cluster,
    output logic [15:0] best_index
);

    localparam logic [15:0] ADDR_COUNT   = 16'h068A;
    localparam logic [15:0] ID_BASE      = 16'h0048;
    localparam logic [15:0] CLUSTER_BASE = 16'h00C8;
    localparam logic [15:0] BATT_BASE    = 16'h0148;
    localparam logic [15:0] Q_BASE       = 16'h01C8;
    localparam logic [15:0] MAX_N        = 16'(MAX_NEIGHBORS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_CHECK,
        S_ID,
        S_BATT,
        S_Q,
        S_CLUST,
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] n;
    logic [15:0] cur_id;
    logic [15:0] cur_batt;
    logic [15:0] n_x2;
    logic [15:0] best_x2;
    logic        eligible;

    // The clamp bounds n, so n never wraps and n*2 stays inside the region.
    function automatic logic [15:0] clamp_count(input logic [15:0] raw);
        return (raw > MAX_N) ? MAX_N : raw;
    endfunction

    assign n_x2    = {n[14:0], 1'b0};
    assign best_x2 = {best_index[14:0], 1'b0};

    // Evaluated in S_Q, where data_in carries the qValue of entry n.
    // Strict '>' keeps the earlier (lower-index) neighbor on a tie.
    always_comb begin
        eligible = (cur_id != exclude_id) &&
                   (cur_batt >= min_battery) &&
                   (!found || (data_in > best_q));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            address      <= 16'h0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            best_id      <= 16'h0000;
            best_q       <= 16'h0000;
            best_cluster <= 16'h0000;
            best_index   <= 16'h0000;
            count        <= 16'h0000;
            n            <= 16'h0000;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        address      <= ADDR_COUNT;
                        found        <= 1'b0;
                        best_id      <= 16'h0000;
                        best_q       <= 16'h0000;
                        best_cluster <= 16'h0000;
                        best_index   <= 16'h0000;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        state        <= S_CNT;
                    end
                end
                S_CNT: begin
                    count <= clamp_count(data_in);
                    n     <= 16'h0000;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (n == count) begin
                        if (found) begin
                            // One extra read fetches the winner's clusterID.
                            address <= CLUSTER_BASE + best_x2;
                            state   <= S_CLUST;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        address <= ID_BASE + n_x2;
                        state   <= S_ID;
                    end
                end
                S_ID: begin
                    address <= BATT_BASE + n_x2;
                    state   <= S_BATT;
                end
                S_BATT: begin
                    address <= Q_BASE + n_x2;
                    state   <= S_Q;
                end
                S_Q: begin
                    if (eligible) begin
                        best_id    <= cur_id;
                        best_q     <= data_in;
                        best_index <= n;
                        found      <= 1'b1;
                    end
                    n     <= n + 16'h0001;
                    state <= S_CHECK;
                end
                S_CLUST: begin
                    best_cluster <= data_in;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-neighbor scratch fields; only meaningful within the entry being read.
    always_ff @(posedge clock) begin
        if (state == S_ID) begin
            cur_id <= data_in;
        end
        if (state == S_BATT) begin
            cur_batt <= data_in;
        end
    end

endmodule
